axil2reg_wr_buf: RTL and testbench



---
 rtl/axil2reg_wr_buf_pkg.sv | 18 +
 rtl/axil2reg_wr_buf_sync_fifo.sv | 62 ++++++
 rtl/axil2reg_wr_buf.sv | 190 +++++++++++++++++++
 tb/tb_axil2reg_wr_buf.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil2reg_wr_buf_pkg.sv
// Shared constants and types for the AXI-Lite to register-bus write buffer.
// No logic of its own; zero latency.
// No flow control of its own; the users of these types handle backpressure.
package axil_pkg;

  // AXI write response codes
  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // Issue FSM: IDLE waits for a complete AW/W pair, BUSY holds reg_wr_en
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wr_state_t;

endpackage

// File: rtl/axil2reg_wr_buf_sync_fifo.sv
// Registered synchronous FIFO with no fall-through.
// A push becomes visible on dout/empty one cycle later.
// A push is ignored while full and a pop is ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axil2reg_wr_buf.sv
// AXI4-Lite write slave buffering AW/W/B in FIFOs and issuing single-word register writes.
// Latency: AW+W accepted in cycle 0 -> reg_wr_en in cycle 2 -> bvalid in cycle 3 (best case).
// awready/wready drop only when their FIFO is full; issue stalls while the B FIFO is full.
module axil2reg_wr_buf
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter longint unsigned       ADDR_SPAN  = 4096,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_ready,
  input  logic                  reg_wr_okay
);

  localparam int              WW      = DATA_WIDTH + STRB_WIDTH;
  localparam int              TW      = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam int              TLAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0]   TLAST   = TLAST_I[TW-1:0];
  localparam bit              TO_EN   = (TIMEOUT != 0);

  // Protection bits carry no meaning for a register file
  logic unused_awprot;
  assign unused_awprot = ^s_axil_awprot;

  wr_state_t           state;
  logic [TW-1:0]       timer;

  logic                aw_push;
  logic                aw_full;
  logic                aw_empty;
  logic [ADDR_WIDTH-1:0] aw_head;

  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [WW-1:0]       w_head;

  logic                pair_pop;
  logic                b_push;
  logic [1:0]          b_push_dat;
  logic                b_pop;
  logic                b_full;
  logic                b_empty;
  logic [1:0]          b_head;

  logic                issue_ok;
  logic [ADDR_WIDTH:0] off_x;
  logic                in_win;

  // Ready is a pure function of occupancy; a same-cycle pop does not help
  assign s_axil_awready = !rst && !aw_full;
  assign s_axil_wready  = !rst && !w_full;
  assign aw_push        = s_axil_awvalid && s_axil_awready;
  assign w_push         = s_axil_wvalid && s_axil_wready;

  assign s_axil_bvalid  = !b_empty;
  assign s_axil_bresp   = b_empty ? AXI_OKAY : b_head;
  assign b_pop          = s_axil_bvalid && s_axil_bready;

  // Issue needs a full pair plus a reserved response slot
  assign issue_ok = !aw_empty && !w_empty && !b_full;

  // One extra bit so an address below the base shows up as a borrow
  assign off_x  = {1'b0, aw_head} - {1'b0, BASE_ADDR};
  assign in_win = !off_x[ADDR_WIDTH] && (64'(off_x[ADDR_WIDTH-1:0]) < ADDR_SPAN);

  sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_aw_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_push),
    .din   (s_axil_awaddr),
    .pop   (pair_pop),
    .dout  (aw_head),
    .full  (aw_full),
    .empty (aw_empty)
  );

  sync_fifo #(.WIDTH(WW), .DEPTH(DEPTH)) u_w_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({s_axil_wdata, s_axil_wstrb}),
    .pop   (pair_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  sync_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_b_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .din   (b_push_dat),
    .pop   (b_pop),
    .dout  (b_head),
    .full  (b_full),
    .empty (b_empty)
  );

  // Retire decisions: decode errors in IDLE, accept or timeout in BUSY
  always_comb begin
    pair_pop   = 1'b0;
    b_push     = 1'b0;
    b_push_dat = AXI_OKAY;
    case (state)
      IDLE: begin
        if (issue_ok && !in_win) begin
          pair_pop   = 1'b1;
          b_push     = 1'b1;
          b_push_dat = AXI_DECERR;
        end
      end
      BUSY: begin
        if (reg_wr_ready) begin
          pair_pop   = 1'b1;
          b_push     = 1'b1;
          b_push_dat = reg_wr_okay ? AXI_OKAY : AXI_SLVERR;
        end else if (TO_EN && (timer == TLAST)) begin
          pair_pop   = 1'b1;
          b_push     = 1'b1;
          b_push_dat = AXI_SLVERR;
        end
      end
      default: begin
        pair_pop   = 1'b0;
        b_push     = 1'b0;
        b_push_dat = AXI_OKAY;
      end
    endcase
  end

  // Issue FSM with registered register-bus outputs, latched once per write
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_ok && in_win) begin
            state       <= BUSY;
            timer       <= '0;
            reg_wr_en   <= 1'b1;
            reg_wr_addr <= off_x[ADDR_WIDTH-1:0];
            reg_wr_data <= w_head[WW-1:STRB_WIDTH];
            reg_wr_strb <= w_head[STRB_WIDTH-1:0];
          end
        end
        BUSY: begin
          if (b_push) begin
            state     <= IDLE;
            reg_wr_en <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          reg_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil2reg_wr_buf.sv
// Self-checking bench for axil2reg_wr_buf: directed scenarios plus a randomized run.
// Expected register writes and responses come from a transaction-level model.
// Drives inputs one time unit after each rising edge and samples there too.
module tb_axil2reg_wr_buf;

  localparam int          DEPTH   = 4;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam longint      SPAN    = 4096;
  localparam int          N       = 40;

  logic        clk;
  logic        rst;
  logic [31:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [31:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en;
  logic        reg_wr_ready;
  logic        reg_wr_okay;

  int vectors = 0;
  int errors  = 0;

  // randomized transaction model
  logic [31:0] r_addr [N];
  logic [31:0] r_data [N];
  logic [3:0]  r_strb [N];
  int          r_wait [N];
  bit          r_ok   [N];
  logic [1:0]  r_exp  [N];
  int          win_q  [$];

  axil2reg_wr_buf #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STRB_WIDTH (4),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .ADDR_SPAN  (SPAN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_strb    (reg_wr_strb),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_ready   (reg_wr_ready),
    .reg_wr_okay    (reg_wr_okay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one AW and one W beat presented together for a single cycle
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axil_awaddr  = a;
    s_axil_awvalid = 1'b1;
    s_axil_wdata   = d;
    s_axil_wstrb   = s;
    s_axil_wvalid  = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint d;
    d = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return (d >= 0) && (d < SPAN);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0; reg_wr_ready = 1'b0; reg_wr_okay = 1'b0;
    #1;
    vectors++; if (s_axil_awready !== 1'b0) begin errors++; $display("FAIL reset_awready_in_rst: got %b want 0", s_axil_awready); end
    tick(); tick();
    rst = 1'b0;
    #1;
    vectors++; if (s_axil_awready !== 1'b1) begin errors++; $display("FAIL reset_awready: got %b want 1", s_axil_awready); end
    vectors++; if (s_axil_wready !== 1'b1) begin errors++; $display("FAIL reset_wready: got %b want 1", s_axil_wready); end
    vectors++; if (s_axil_bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b want 0", s_axil_bvalid); end
    vectors++; if (s_axil_bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp: got %b want 00", s_axil_bresp); end
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", reg_wr_en); end
    vectors++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== 68'h0) begin
      errors++; $display("FAIL reset_regbus: got %h/%h/%h want zeros", reg_wr_addr, reg_wr_data, reg_wr_strb);
    end
  endtask

  task automatic test_single();
    reg_wr_ready = 1'b1; reg_wr_okay = 1'b1; s_axil_bready = 1'b0;
    send(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);   // now in cycle 1
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL single_en_c1: got %b want 0", reg_wr_en); end
    tick();                                      // cycle 2
    vectors++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL single_en_c2: got %b want 1", reg_wr_en); end
    vectors++; if (reg_wr_addr !== 32'h10) begin errors++; $display("FAIL single_addr: got %h want 10", reg_wr_addr); end
    vectors++; if (reg_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", reg_wr_data); end
    vectors++; if (reg_wr_strb !== 4'hF) begin errors++; $display("FAIL single_strb: got %h want f", reg_wr_strb); end
    tick();                                      // cycle 3
    vectors++; if (s_axil_bvalid !== 1'b1) begin errors++; $display("FAIL single_bvalid_c3: got %b want 1", s_axil_bvalid); end
    vectors++; if (s_axil_bresp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b want 00", s_axil_bresp); end
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL single_en_c3: got %b want 0", reg_wr_en); end
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    vectors++; if (s_axil_bvalid !== 1'b0) begin errors++; $display("FAIL single_bvalid_after: got %b want 0", s_axil_bvalid); end
  endtask

  task automatic test_w_before_aw();
    reg_wr_ready = 1'b1; reg_wr_okay = 1'b1; s_axil_bready = 1'b0;
    s_axil_wdata = 32'h1234_5678; s_axil_wstrb = 4'h3; s_axil_wvalid = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL wfirst_early_en c%0d: got %b want 0", c, reg_wr_en); end
      tick();
    end
    s_axil_awaddr = BASE + 32'h24; s_axil_awvalid = 1'b1;   // cycle 5
    tick();
    s_axil_awvalid = 1'b0;
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL wfirst_en_c6: got %b want 0", reg_wr_en); end
    tick();                                                 // cycle 7
    vectors++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL wfirst_en_c7: got %b want 1", reg_wr_en); end
    vectors++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== {32'h24, 32'h1234_5678, 4'h3}) begin
      errors++; $display("FAIL wfirst_payload: got %h/%h/%h want 24/12345678/3", reg_wr_addr, reg_wr_data, reg_wr_strb);
    end
    tick();
    vectors++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
      errors++; $display("FAIL wfirst_b: got valid=%b resp=%b want 1/00", s_axil_bvalid, s_axil_bresp);
    end
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] ad [3];
    logic [1:0]  ex [3];
    int nb, nen;
    ad[0] = 32'h0000_0FFC; ex[0] = 2'b11;   // just below the window
    ad[1] = 32'h0000_2000; ex[1] = 2'b11;   // first byte past the window
    ad[2] = 32'h0000_1FFC; ex[2] = 2'b00;   // last word inside the window
    reg_wr_ready = 1'b1; reg_wr_okay = 1'b1; s_axil_bready = 1'b0;
    for (int i = 0; i < 3; i++) send(ad[i], 32'hC0DE_0000 + i, 4'hF);
    nb = 0; nen = 0;
    s_axil_bready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (reg_wr_en) begin
        nen++;
        vectors++; if (reg_wr_addr !== 32'hFFC) begin errors++; $display("FAIL decode_addr: got %h want ffc", reg_wr_addr); end
      end
      if (s_axil_bvalid) begin
        vectors++;
        if (nb > 2 || s_axil_bresp !== ex[nb > 2 ? 2 : nb]) begin
          errors++; $display("FAIL decode_bresp[%0d]: got %b want %b", nb, s_axil_bresp, ex[nb > 2 ? 2 : nb]);
        end
        nb++;
      end
      tick();
    end
    s_axil_bready = 1'b0;
    vectors++; if (nb != 3) begin errors++; $display("FAIL decode_bcount: got %0d want 3", nb); end
    vectors++; if (nen != 1) begin errors++; $display("FAIL decode_en_cycles: got %0d want 1", nen); end
  endtask

  task automatic test_timeout();
    int cnt, last_en, first_b, nb, g;
    reg_wr_ready = 1'b0; reg_wr_okay = 1'b1; s_axil_bready = 1'b1;
    send(BASE + 32'h80, 32'h5555_AAAA, 4'hF);
    cnt = 0; last_en = -1; first_b = -1; nb = 0;
    for (int c = 1; c < 40; c++) begin
      if (reg_wr_en) begin cnt++; last_en = c; end
      if (s_axil_bvalid) begin
        if (first_b < 0) first_b = c;
        nb++;
        vectors++; if (s_axil_bresp !== 2'b10) begin errors++; $display("FAIL timeout_bresp: got %b want 10", s_axil_bresp); end
      end
      tick();
    end
    vectors++; if (cnt != TIMEOUT) begin errors++; $display("FAIL timeout_en_cycles: got %0d want %0d", cnt, TIMEOUT); end
    vectors++; if (first_b != last_en + 1) begin errors++; $display("FAIL timeout_b_cycle: got %0d want %0d", first_b, last_en + 1); end
    vectors++; if (nb != 1) begin errors++; $display("FAIL timeout_bcount: got %0d want 1", nb); end
    // accepted but reported as failing by the register file
    reg_wr_ready = 1'b1; reg_wr_okay = 1'b0; s_axil_bready = 1'b0;
    send(BASE + 32'h84, 32'h0F0F_0F0F, 4'h1);
    g = 0;
    while (!s_axil_bvalid && g < 20) begin tick(); g++; end
    vectors++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b10) begin
      errors++; $display("FAIL notokay_b: got valid=%b resp=%b want 1/10", s_axil_bvalid, s_axil_bresp);
    end
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
    reg_wr_okay = 1'b1;
  endtask

  task automatic test_backpressure();
    int ai, wi, nreg, nb;
    ai = 0; wi = 0; nreg = 0; nb = 0;
    reg_wr_ready = 1'b1;
    for (int c = 0; c < 90; c++) begin
      s_axil_awvalid = (ai < 12);
      s_axil_awaddr  = BASE + 32'(ai * 4);
      s_axil_wvalid  = (wi < 12);
      s_axil_wdata   = 32'hA000_0000 + 32'(wi);
      s_axil_wstrb   = 4'hF;
      // even-indexed writes succeed, odd ones report an error
      reg_wr_okay    = (reg_wr_addr[2] == 1'b0);
      s_axil_bready  = (c >= 30);
      if (c == 29) begin
        vectors++; if (ai != 8 || wi != 8) begin errors++; $display("FAIL bp_accepted: got aw=%0d w=%0d want 8/8", ai, wi); end
        vectors++; if (nreg != 4) begin errors++; $display("FAIL bp_regwrites: got %0d want 4", nreg); end
        vectors++; if (s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0) begin
          errors++; $display("FAIL bp_ready: got aw=%b w=%b want 0/0", s_axil_awready, s_axil_wready);
        end
        vectors++; if (s_axil_bvalid !== 1'b1) begin errors++; $display("FAIL bp_bvalid: got %b want 1", s_axil_bvalid); end
      end
      if (reg_wr_en && reg_wr_ready) begin
        vectors++; if (reg_wr_addr !== 32'(nreg * 4) || reg_wr_data !== 32'hA000_0000 + 32'(nreg)) begin
          errors++; $display("FAIL bp_reg[%0d]: got %h/%h want %h/%h", nreg, reg_wr_addr, reg_wr_data, nreg * 4, 32'hA000_0000 + 32'(nreg));
        end
        nreg++;
      end
      if (s_axil_bvalid && s_axil_bready) begin
        vectors++; if (s_axil_bresp !== ((nb % 2 == 0) ? 2'b00 : 2'b10)) begin
          errors++; $display("FAIL bp_bresp[%0d]: got %b want %b", nb, s_axil_bresp, (nb % 2 == 0) ? 2'b00 : 2'b10);
        end
        nb++;
      end
      if (s_axil_awvalid && s_axil_awready) ai++;
      if (s_axil_wvalid && s_axil_wready) wi++;
      tick();
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; reg_wr_okay = 1'b1;
    vectors++; if (nb != 12) begin errors++; $display("FAIL bp_bcount: got %0d want 12", nb); end
    vectors++; if (nreg != 12) begin errors++; $display("FAIL bp_regcount: got %0d want 12", nreg); end
  endtask

  task automatic test_reset_busy();
    int g, nen, nb;
    reg_wr_ready = 1'b0; reg_wr_okay = 1'b1; s_axil_bready = 1'b0;
    for (int i = 0; i < 4; i++) send(BASE + 32'(16 * i), 32'hBEEF_0000 + 32'(i), 4'hF);
    tick(); tick();
    vectors++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL rbusy_en_before: got %b want 1", reg_wr_en); end
    rst = 1'b1;
    #1;
    vectors++; if (s_axil_awready !== 1'b0) begin errors++; $display("FAIL rbusy_awready_in_rst: got %b want 0", s_axil_awready); end
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL rbusy_en_after: got %b want 0", reg_wr_en); end
    vectors++; if (s_axil_bvalid !== 1'b0) begin errors++; $display("FAIL rbusy_bvalid: got %b want 0", s_axil_bvalid); end
    vectors++; if (s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1) begin
      errors++; $display("FAIL rbusy_ready: got aw=%b w=%b want 1/1", s_axil_awready, s_axil_wready);
    end
    reg_wr_ready = 1'b1; s_axil_bready = 1'b1;
    nen = 0; nb = 0;
    for (int c = 0; c < 8; c++) begin
      if (reg_wr_en) nen++;
      if (s_axil_bvalid) nb++;
      tick();
    end
    vectors++; if (nen != 0 || nb != 0) begin errors++; $display("FAIL rbusy_drained: got en=%0d b=%0d want 0/0", nen, nb); end
    s_axil_bready = 1'b0;
    send(BASE + 32'h40, 32'h7777_1111, 4'h9);
    g = 0;
    while (!s_axil_bvalid && g < 20) begin tick(); g++; end
    vectors++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
      errors++; $display("FAIL rbusy_new_b: got valid=%b resp=%b want 1/00", s_axil_bvalid, s_axil_bresp);
    end
    vectors++; if (reg_wr_addr !== 32'h40 || reg_wr_data !== 32'h7777_1111) begin
      errors++; $display("FAIL rbusy_new_reg: got %h/%h want 40/77771111", reg_wr_addr, reg_wr_data);
    end
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
  endtask

  task automatic test_random();
    win_q.delete();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       r_addr[i] = BASE - 32'(4 * $urandom_range(1, 64));
        1:       r_addr[i] = BASE + 32'(SPAN) + 32'(4 * $urandom_range(0, 64));
        default: r_addr[i] = BASE + 32'(4 * $urandom_range(0, 1023));
      endcase
      r_data[i] = $urandom;
      r_strb[i] = 4'($urandom_range(0, 15));
      r_wait[i] = $urandom_range(0, 20);
      r_ok[i]   = 1'($urandom_range(0, 1));
      if (!in_window(r_addr[i]))  r_exp[i] = 2'b11;
      else if (r_wait[i] >= TIMEOUT) r_exp[i] = 2'b10;
      else                        r_exp[i] = r_ok[i] ? 2'b00 : 2'b10;
      if (in_window(r_addr[i])) win_q.push_back(i);
    end
    reg_wr_ready = 1'b0; reg_wr_okay = 1'b0; s_axil_bready = 1'b0;
    fork
      begin : aw_drv
        for (int i = 0; i < N; i++) begin
          int g;
          s_axil_awvalid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          s_axil_awaddr = r_addr[i]; s_axil_awvalid = 1'b1;
          g = 0;
          while (!s_axil_awready && g < 2000) begin tick(); g++; end
          vectors++; if (g >= 2000) begin errors++; $display("FAIL rand_aw_stall[%0d]: got no awready want awready", i); end
          tick();
        end
        s_axil_awvalid = 1'b0;
      end
      begin : w_drv
        for (int i = 0; i < N; i++) begin
          int g;
          s_axil_wvalid = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
          s_axil_wdata = r_data[i]; s_axil_wstrb = r_strb[i]; s_axil_wvalid = 1'b1;
          g = 0;
          while (!s_axil_wready && g < 2000) begin tick(); g++; end
          vectors++; if (g >= 2000) begin errors++; $display("FAIL rand_w_stall[%0d]: got no wready want wready", i); end
          tick();
        end
        s_axil_wvalid = 1'b0;
      end
      begin : reg_file
        for (int k = 0; k < win_q.size(); k++) begin
          int idx, g, cnt;
          idx = win_q[k];
          g = 0;
          while (!reg_wr_en && g < 3000) begin tick(); g++; end
          vectors++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL rand_reg_wait[%0d]: got no reg_wr_en want one", k); break; end
          vectors++; if (reg_wr_addr !== r_addr[idx] - BASE) begin errors++; $display("FAIL rand_reg_addr[%0d]: got %h want %h", idx, reg_wr_addr, r_addr[idx] - BASE); end
          vectors++; if (reg_wr_data !== r_data[idx]) begin errors++; $display("FAIL rand_reg_data[%0d]: got %h want %h", idx, reg_wr_data, r_data[idx]); end
          vectors++; if (reg_wr_strb !== r_strb[idx]) begin errors++; $display("FAIL rand_reg_strb[%0d]: got %h want %h", idx, reg_wr_strb, r_strb[idx]); end
          if (r_wait[idx] < TIMEOUT) begin
            repeat (r_wait[idx]) tick();
            vectors++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL rand_reg_hold[%0d]: got %b want 1", idx, reg_wr_en); end
            reg_wr_ready = 1'b1; reg_wr_okay = r_ok[idx];
            tick();
            reg_wr_ready = 1'b0; reg_wr_okay = 1'b0;
            vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL rand_reg_drop[%0d]: got %b want 0", idx, reg_wr_en); end
          end else begin
            cnt = 0;
            while (reg_wr_en && cnt < 100) begin cnt++; tick(); end
            vectors++; if (cnt != TIMEOUT) begin errors++; $display("FAIL rand_timeout_len[%0d]: got %0d want %0d", idx, cnt, TIMEOUT); end
          end
        end
      end
      begin : b_chk
        int j, g;
        j = 0; g = 0;
        while (j < N && g < 8000) begin
          s_axil_bready = ($urandom_range(0, 3) != 0);
          if (s_axil_bvalid && s_axil_bready) begin
            vectors++; if (s_axil_bresp !== r_exp[j]) begin errors++; $display("FAIL rand_bresp[%0d]: got %b want %b", j, s_axil_bresp, r_exp[j]); end
            j++;
          end
          tick(); g++;
        end
        s_axil_bready = 1'b0;
        vectors++; if (j != N) begin errors++; $display("FAIL rand_bcount: got %0d want %0d", j, N); end
      end
    join
    repeat (4) tick();
    vectors++; if (s_axil_bvalid !== 1'b0 || reg_wr_en !== 1'b0) begin
      errors++; $display("FAIL rand_idle: got bvalid=%b en=%b want 0/0", s_axil_bvalid, reg_wr_en);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_w_before_aw();
    test_decode();
    test_timeout();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
